tube_scheduler: RTL and testbench
=================================

// Module: tube_scheduler
// PURPOSE
//  Time-shares the two-digit seven-segment driver (digit_tube) between N_REQ client blocks.
//  Each client posts a display request: two 5-bit digit codes, a 3-bit brightness and a hold time.
//  The scheduler grants one request at a time and latches its content onto the driver inputs.
//  It holds that content for the requested number of time-base ticks, then shows a one-tick blank gap.
//  Client 0 is the urgent/alert channel: it preempts any other owner.
//  Clients 1..N_REQ-1 are served round-robin. Sits between the status/alert producers and digit_tube.
// PARAMETERS
//  N_REQ      4        number of clients, 2..8; client 0 = urgent
//  HOLD_W     12       width of the hold-time field and of the hold counter
//  OWN_W      3        owner index width, >= clog2(N_REQ)
// PORTS
//  per_clk     in   1           clock, shared with digit_tube
//  rst_n       in   1           reset, synchronous, active-low
//  tick        in   1           1-cycle time-base strobe (hold/gap unit)
//  req         in   N_REQ       per-client request level
//  req_a       in   5*N_REQ     per-client digit A code, slice i = [5i+4:5i]
//  req_b       in   5*N_REQ     per-client digit B code
//  req_bright  in   3*N_REQ     per-client brightness
//  req_hold    in   HOLD_W*N_REQ per-client hold time in ticks; 0 treated as 1
//  grant       out  N_REQ       one-hot, 1-cycle pulse when a request is accepted
//  busy        out  1           1 while in SHOW or GAP
//  owner       out  OWN_W       index of current/last granted client
//  data_A      out  5           to digit_tube data_A
//  data_B      out  5           to digit_tube data_B
//  bright      out  3           to digit_tube bright
// BEHAVIOUR
//  All outputs registered. Reset (rst_n=0 at per_clk edge): state=IDLE, data_A=data_B=CODE_BLANK(5'b10001),
//   bright=0, grant=0, busy=0, owner=0, rr pointer=1, hold counter=0. Reset mid-SHOW aborts silently.
//  States: IDLE, SHOW, GAP.
//  IDLE: any req bit set -> accept this cycle. Client 0 wins if set; otherwise first set bit at or after rr
//   pointer among 1..N_REQ-1, wrapping. Next edge: grant[i]=1 (one cycle), owner=i, data_A/B/bright latched
//   from slice i, hold counter=max(req_hold_i,1), busy=1, state=SHOW. Latency req->outputs: 1 cycle.
//  Round-robin: granting client i>=1 sets rr pointer to i+1 (wrap to 1). Granting client 0 leaves pointer unchanged.
//  SHOW: each tick decrements hold counter; tick with counter==1 -> state=GAP, data_A=data_B=CODE_BLANK,
//   bright=0, gap counter=1. Content is latched; req/slice changes during SHOW are ignored.
//  Preempt: in SHOW with owner!=0 and req[0]=1 -> re-grant client 0 immediately (same rules as IDLE accept).
//   No gap is inserted. Preempt beats a simultaneous expiring tick. Owner 0 is never preempted; a
//   re-request by client 0 during its own SHOW waits for the GAP.
//  GAP: next tick -> IDLE, busy=0. Outputs stay blank. A request is accepted on the cycle after GAP ends
//   (minimum one IDLE cycle).
//  Clients must drop req after seeing grant. A req still high in IDLE is treated as a new request.
//  tick is ignored in IDLE. HOLD_W arithmetic is unsigned. Counters never underflow: a load of 0 becomes 1.
// STRUCTURE
//  Shared header tube_defs.vh (`ifndef guarded): CODE_BLANK=5'b10001, CODE_H=5'b10000, digit codes 0..F,
//   state encodings ST_IDLE/ST_SHOW/ST_GAP.
//  Sub-module rr_arbiter (N, pointer in, req in, one-hot grant out, combinational) for clients 1..N_REQ-1.
//   Urgent override and FSM stay in tube_scheduler.
// TESTING
//  1 Reset: hold rst_n=0 three cycles -> data_A=data_B=5'h11, bright=0, busy=0, grant=0. Async glitch on rst_n
//    between edges has no effect.
//  2 Single client: req[2]=1, a=5'h3, b=5'h7, bright=5, hold=3 -> grant=4'b0100 one cycle later.
//    Outputs 3/7/5 for exactly 3 ticks, then 1 blank tick, then busy=0.
//  3 Round-robin: req=4'b1110 held, hold=1 each -> grants in order 1,2,3,1, each separated by SHOW+GAP.
//  4 Preempt: client 1 in SHOW (hold=100), after 10 ticks req[0]=1, a=5'h10 -> next edge grant=4'b0001,
//    data_A=5'h10, owner=0. Client 2 pending is served after client 0's gap; pointer still 2.
//  5 Boundary: hold=0 -> shows for 1 tick. req[0] and expiring tick in the same cycle -> preempt wins, no blank.
//  6 Reset mid-SHOW: rst_n=0 for 1 cycle during SHOW -> IDLE with blank outputs. Next grant goes to the
//    lowest requesting client >=1 (pointer=1).

Source files
------------

// File: rtl/tube_scheduler_pkg.sv
// Shared digit codes and FSM state encoding for the seven-segment display scheduler.
package tube_scheduler_pkg;

  localparam logic [4:0] CODE_BLANK = 5'b10001;
  localparam logic [4:0] CODE_H     = 5'b10000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  // Hex digit codes 0..F are the digit value with the MSB clear.
  function automatic logic [4:0] digit_code(input logic [3:0] d);
    return {1'b0, d};
  endfunction

endpackage

// File: rtl/tube_scheduler_rr_arbiter.sv
// Combinational round-robin picker: first requester at or after the pointer, wrapping to bit 0.
// The scheduler masks the urgent client out of i_req, so the wrap effectively lands on client 1.
module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = 3
) (
  input  logic [PTR_W-1:0] i_ptr,
  input  logic [N-1:0]     i_req,
  output logic [N-1:0]     o_grant
);

  logic w_found;

  // Two passes: requesters at/after the pointer win, then anything from the bottom.
  always_comb begin
    o_grant = '0;
    w_found = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[i] && (PTR_W'(i) >= i_ptr)) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!w_found && i_req[i]) begin
        o_grant[i] = 1'b1;
        w_found    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/tube_scheduler.sv
// Time-shares the two-digit tube driver between clients; client 0 is the urgent channel.
//
//   state   | meaning
//   --------+---------------------------------------------------------------
//   ST_IDLE | no owner, outputs blank, any request is accepted next edge
//   ST_SHOW | owner content latched, hold counter counts down on tick
//   ST_GAP  | blank outputs for one tick before returning to idle
module tube_scheduler
  import tube_scheduler_pkg::*;
#(
  parameter int N_REQ  = 4,
  parameter int HOLD_W = 12,
  parameter int OWN_W  = 3
) (
  input  logic                      per_clk,
  input  logic                      rst_n,
  input  logic                      tick,
  input  logic [N_REQ-1:0]          req,
  input  logic [5*N_REQ-1:0]        req_a,
  input  logic [5*N_REQ-1:0]        req_b,
  input  logic [3*N_REQ-1:0]        req_bright,
  input  logic [HOLD_W*N_REQ-1:0]   req_hold,
  output logic [N_REQ-1:0]          grant,
  output logic                      busy,
  output logic [OWN_W-1:0]          owner,
  output logic [4:0]                data_A,
  output logic [4:0]                data_B,
  output logic [2:0]                bright
);

  state_t              r_state;
  logic [N_REQ-1:0]    r_grant;
  logic                r_busy;
  logic [OWN_W-1:0]    r_owner;
  logic [OWN_W-1:0]    r_rr_ptr;
  logic [4:0]          r_data_a;
  logic [4:0]          r_data_b;
  logic [2:0]          r_bright;
  logic [HOLD_W-1:0]   r_hold;

  logic [N_REQ-1:0]    w_rr_req;
  logic [N_REQ-1:0]    w_rr_grant;
  logic [OWN_W-1:0]    w_rr_idx;
  logic [OWN_W-1:0]    w_sel;
  logic [OWN_W-1:0]    w_ptr_next;
  logic [4:0]          w_a;
  logic [4:0]          w_b;
  logic [2:0]          w_bright;
  logic [HOLD_W-1:0]   w_hold_raw;
  logic [HOLD_W-1:0]   w_hold_load;
  logic                w_preempt;
  logic                w_accept;

  assign w_rr_req = {req[N_REQ-1:1], 1'b0};

  rr_arbiter #(
    .N     (N_REQ),
    .PTR_W (OWN_W)
  ) u_rr_arbiter (
    .i_ptr   (r_rr_ptr),
    .i_req   (w_rr_req),
    .o_grant (w_rr_grant)
  );

  // Winner index: urgent client 0 overrides the round-robin choice.
  always_comb begin
    w_rr_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_rr_grant[i]) w_rr_idx = OWN_W'(i);
    end
    w_sel = req[0] ? '0 : w_rr_idx;
  end

  // Select the winning client's request slice.
  always_comb begin
    w_a        = '0;
    w_b        = '0;
    w_bright   = '0;
    w_hold_raw = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (w_sel == OWN_W'(i)) begin
        w_a        = req_a[5*i +: 5];
        w_b        = req_b[5*i +: 5];
        w_bright   = req_bright[3*i +: 3];
        w_hold_raw = req_hold[HOLD_W*i +: HOLD_W];
      end
    end
  end

  // A zero hold still shows for one tick; the counter is never loaded with 0.
  assign w_hold_load = (w_hold_raw == '0) ? HOLD_W'(1) : w_hold_raw;
  assign w_ptr_next  = (w_sel == OWN_W'(N_REQ-1)) ? OWN_W'(1) : w_sel + OWN_W'(1);
  assign w_preempt   = (r_state == ST_SHOW) && (r_owner != '0) && req[0];
  assign w_accept    = ((r_state == ST_IDLE) && (|req)) || w_preempt;

  // Scheduler FSM with registered outputs; preemption takes priority over an expiring tick.
  always_ff @(posedge per_clk) begin
    if (!rst_n) begin
      r_state  <= ST_IDLE;
      r_grant  <= '0;
      r_busy   <= 1'b0;
      r_owner  <= '0;
      r_rr_ptr <= OWN_W'(1);
      r_data_a <= CODE_BLANK;
      r_data_b <= CODE_BLANK;
      r_bright <= '0;
      r_hold   <= '0;
    end else begin
      r_grant <= '0;
      if (w_accept) begin
        r_state  <= ST_SHOW;
        r_grant  <= {{(N_REQ-1){1'b0}}, 1'b1} << w_sel;
        r_busy   <= 1'b1;
        r_owner  <= w_sel;
        r_data_a <= w_a;
        r_data_b <= w_b;
        r_bright <= w_bright;
        r_hold   <= w_hold_load;
        if (w_sel != '0) r_rr_ptr <= w_ptr_next;
      end else begin
        case (r_state)
          ST_SHOW: begin
            if (tick) begin
              if (r_hold <= HOLD_W'(1)) begin
                r_state  <= ST_GAP;
                r_data_a <= CODE_BLANK;
                r_data_b <= CODE_BLANK;
                r_bright <= '0;
                r_hold   <= HOLD_W'(1);
              end else begin
                r_hold <= r_hold - HOLD_W'(1);
              end
            end
          end
          ST_GAP: begin
            if (tick) begin
              r_state <= ST_IDLE;
              r_busy  <= 1'b0;
              r_hold  <= '0;
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign grant  = r_grant;
  assign busy   = r_busy;
  assign owner  = r_owner;
  assign data_A = r_data_a;
  assign data_B = r_data_b;
  assign bright = r_bright;

endmodule

// File: tb/tb_tube_scheduler.sv
// Scoreboard bench for tube_scheduler: stimulus pushes expected grants, a monitor checks them.
module tb_tube_scheduler;
  import tube_scheduler_pkg::*;

  localparam int N  = 4;
  localparam int HW = 12;
  localparam int OW = 3;

  logic              per_clk = 1'b0;
  logic              rst_n   = 1'b0;
  logic              tick    = 1'b0;
  logic [N-1:0]      req        = '0;
  logic [5*N-1:0]    req_a      = '0;
  logic [5*N-1:0]    req_b      = '0;
  logic [3*N-1:0]    req_bright = '0;
  logic [HW*N-1:0]   req_hold   = '0;
  logic [N-1:0]      grant;
  logic              busy;
  logic [OW-1:0]     owner;
  logic [4:0]        data_A;
  logic [4:0]        data_B;
  logic [2:0]        bright;

  always #5 per_clk = ~per_clk;

  tube_scheduler #(.N_REQ(N), .HOLD_W(HW), .OWN_W(OW)) dut (
    .per_clk    (per_clk),
    .rst_n      (rst_n),
    .tick       (tick),
    .req        (req),
    .req_a      (req_a),
    .req_b      (req_b),
    .req_bright (req_bright),
    .req_hold   (req_hold),
    .grant      (grant),
    .busy       (busy),
    .owner      (owner),
    .data_A     (data_A),
    .data_B     (data_B),
    .bright     (bright)
  );

  typedef struct {
    int         idx;
    logic [4:0] a;
    logic [4:0] b;
    logic [2:0] br;
    int         hold;
    bit         pre;
  } exp_t;

  exp_t exp_q[$];
  int   total = 0;
  int   bad   = 0;
  int   tick_mode = 0;   // 0 none, 1 random, 2 every cycle
  int   model_ptr = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    total++;
    if (act !== want) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, want, $time);
    end
  endtask

  // Reference arbitration: urgent first, then the first pending client at or after the pointer.
  function automatic int model_pick(input logic [N-1:0] pend);
    if (pend[0]) return 0;
    for (int k = 0; k < N-1; k++) begin
      int c;
      c = ((model_ptr - 1 + k) % (N-1)) + 1;
      if (pend[c]) begin
        model_ptr = (c == N-1) ? 1 : c + 1;
        return c;
      end
    end
    return -1;
  endfunction

  task automatic set_client(input int i, input logic [4:0] a, input logic [4:0] b,
                            input logic [2:0] br, input int hold);
    req_a[5*i +: 5]       = a;
    req_b[5*i +: 5]       = b;
    req_bright[3*i +: 3]  = br;
    req_hold[HW*i +: HW]  = HW'(hold);
  endtask

  task automatic push_exp(input int i, input bit pre);
    exp_t e;
    e.idx  = i;
    e.a    = req_a[5*i +: 5];
    e.b    = req_b[5*i +: 5];
    e.br   = req_bright[3*i +: 3];
    e.hold = int'(req_hold[HW*i +: HW]);
    if (e.hold == 0) e.hold = 1;
    e.pre  = pre;
    exp_q.push_back(e);
  endtask

  // One clock; granted clients drop their request, tick follows the current mode.
  task automatic step();
    @(posedge per_clk);
    #1;
    for (int i = 0; i < N; i++) if (grant[i] === 1'b1) req[i] = 1'b0;
    case (tick_mode)
      1:       tick = 1'($urandom_range(0, 1));
      2:       tick = 1'b1;
      default: tick = 1'b0;
    endcase
  endtask

  task automatic serve_set(input logic [N-1:0] set);
    logic [N-1:0] pend;
    int c;
    pend = set;
    while (pend != '0) begin
      c = model_pick(pend);
      push_exp(c, 1'b0);
      pend[c] = 1'b0;
    end
    req = req | set;
  endtask

  task automatic wait_idle(input int budget);
    int n;
    n = 0;
    step();
    while ((exp_q.size() != 0 || busy !== 1'b0) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", 32'(n < budget), 32'd1);
    step();
  endtask

  // Monitor: phase 0 idle, 1 showing, 2 gap.
  int   phase  = 0;
  int   ticks  = 0;
  int   gticks = 0;
  exp_t cur;

  always @(negedge per_clk) begin
    if (rst_n !== 1'b1) begin
      phase = 0;
    end else begin
      if (grant !== '0) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_grant", 32'(grant), 32'd0);
        end else begin
          cur = exp_q.pop_front();
          chk("grant_vec",   32'(grant),  32'(1 << cur.idx));
          chk("grant_phase", 32'(phase),  cur.pre ? 32'd1 : 32'd0);
          chk("grant_owner", 32'(owner),  32'(cur.idx));
          chk("grant_A",     32'(data_A), 32'(cur.a));
          chk("grant_B",     32'(data_B), 32'(cur.b));
          chk("grant_br",    32'(bright), 32'(cur.br));
          chk("grant_busy",  32'(busy),   32'd1);
          phase = 1;
          ticks = 0;
        end
      end else begin
        case (phase)
          1: begin
            if (data_A === CODE_BLANK && data_B === CODE_BLANK && bright === 3'd0) begin
              chk("hold_ticks", 32'(ticks), 32'(cur.hold));
              chk("gap_busy",   32'(busy),  32'd1);
              phase  = 2;
              gticks = 0;
            end else begin
              chk("show_A",     32'(data_A), 32'(cur.a));
              chk("show_B",     32'(data_B), 32'(cur.b));
              chk("show_br",    32'(bright), 32'(cur.br));
              chk("show_owner", 32'(owner),  32'(cur.idx));
              chk("show_busy",  32'(busy),   32'd1);
            end
          end
          2: begin
            chk("gap_blank", 32'({data_A, data_B, bright}), 32'({CODE_BLANK, CODE_BLANK, 3'd0}));
            if (busy === 1'b0) begin
              chk("gap_len", 32'(gticks), 32'd1);
              phase = 0;
            end
          end
          default: begin
            chk("idle_busy",  32'(busy), 32'd0);
            chk("idle_blank", 32'({data_A, data_B, bright}), 32'({CODE_BLANK, CODE_BLANK, 3'd0}));
          end
        endcase
      end
      if (tick === 1'b1) begin
        if (phase == 1) ticks++;
        else if (phase == 2) gticks++;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset held for three cycles.
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_A",     32'(data_A), 32'h11);
    chk("rst_B",     32'(data_B), 32'h11);
    chk("rst_br",    32'(bright), 32'd0);
    chk("rst_busy",  32'(busy),   32'd0);
    chk("rst_grant", 32'(grant),  32'd0);
    chk("rst_owner", 32'(owner),  32'd0);
    rst_n = 1'b1;
    step();

    // Urgent preempt of client 1 while client 2 waits.
    tick_mode = 2;
    set_client(1, 5'h4, 5'h5, 3'd1, 100);
    set_client(2, 5'h8, 5'h9, 3'd2, 2);
    set_client(0, CODE_H, 5'h2, 3'd7, 2);
    push_exp(model_pick(4'b0010), 1'b0);
    req = 4'b0110;
    step();
    repeat (10) step();
    push_exp(model_pick(4'b0101), 1'b1);
    push_exp(model_pick(4'b0100), 1'b0);
    req[0] = 1'b1;
    wait_idle(600);

    // Single client with an rst_n glitch between edges.
    tick_mode = 1;
    set_client(2, 5'h3, 5'h7, 3'd5, 3);
    serve_set(4'b0100);
    step();
    step();
    #2 rst_n = 1'b0;
    #1 rst_n = 1'b1;
    wait_idle(600);

    // Round-robin across clients 1..3 with hold 1.
    for (int i = 1; i < N; i++)
      set_client(i, digit_code(4'(i)), digit_code(4'(i + 8)), 3'(i), 1);
    serve_set(4'b1110);
    wait_idle(600);
    serve_set(4'b1110);
    wait_idle(600);

    // Hold 0 plus urgent request colliding with the expiring tick, then urgent re-request.
    tick_mode = 2;
    set_client(1, 5'h6, 5'h1, 3'd3, 0);
    set_client(0, CODE_H, 5'hE, 3'd6, 3);
    push_exp(model_pick(4'b0010), 1'b0);
    req[1] = 1'b1;
    step();
    push_exp(model_pick(4'b0001), 1'b1);
    req[0] = 1'b1;
    step();
    step();
    push_exp(model_pick(4'b0001), 1'b0);
    req[0] = 1'b1;
    wait_idle(600);

    // Reset in the middle of a long show.
    tick_mode = 1;
    set_client(2, 5'hA, 5'hB, 3'd4, 50);
    serve_set(4'b0100);
    repeat (4) step();
    chk("grant_before_reset", 32'(exp_q.size()), 32'd0);
    exp_q.delete();
    rst_n = 1'b0;
    model_ptr = 1;
    step();
    rst_n = 1'b1;
    step();
    chk("midrst_busy", 32'(busy),   32'd0);
    chk("midrst_A",    32'(data_A), 32'(CODE_BLANK));
    chk("midrst_br",   32'(bright), 32'd0);
    set_client(1, 5'hC, 5'hD, 3'd1, 2);
    set_client(3, 5'hF, 5'h0, 3'd2, 1);
    serve_set(4'b1010);
    wait_idle(600);

    // Random request sets.
    tick_mode = 1;
    for (int it = 0; it < 30; it++) begin
      for (int i = 0; i < N; i++)
        set_client(i, digit_code(4'($urandom_range(0, 15))), digit_code(4'($urandom_range(0, 15))),
                   3'($urandom_range(0, 7)), int'($urandom_range(0, 4)));
      serve_set(4'($urandom_range(1, 15)));
      wait_idle(600);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
